// File: rtl/packer_fifo_sched_pkg.sv
// Shared types and the round-robin selection helper for the packer FIFO scheduler.
package packer_fifo_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    localparam int unsigned MaxReq = 32;
    localparam int unsigned IdxW   = $clog2(MaxReq);

    // First set bit of elig at or above ptr, wrapping at num_req; 0 when nothing is set.
    function automatic int unsigned rr_pick(
        input logic [MaxReq-1:0] elig,
        input int unsigned       ptr,
        input int unsigned       num_req
    );
        int unsigned pick;
        int unsigned ofs;
        int unsigned idx;
        pick = 0;
        // Scan farthest offset first so the nearest eligible index overwrites last.
        for (int unsigned n = 0; n < MaxReq; n++) begin
            ofs = MaxReq - 1 - n;
            if (ofs < num_req) begin
                idx = ptr + ofs;
                if (idx >= num_req) begin
                    idx = idx - num_req;
                end
                if (elig[idx[IdxW-1:0]]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/packer_fifo_sched_rr_pick.sv
// Combinational round-robin picker: lowest eligible index at or after ptr_i, wrapping.
module packer_fifo_sched_rr_pick
    import packer_fifo_sched_pkg::*;
#(
    parameter  int unsigned NumReq = 4,
    localparam int unsigned IdW    = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] elig_i,
    input  logic [IdW-1:0]    ptr_i,
    output logic [IdW-1:0]    idx_o,
    output logic              any_o
);

    always_comb begin
        any_o = |elig_i;
        idx_o = IdW'(rr_pick(MaxReq'(elig_i), 32'(ptr_i), NumReq));
    end

endmodule

// File: rtl/packer_fifo_sched.sv
// Arbitrates NumReq narrow requesters onto one packer write port, one owner per packed word,
// and tags each popped word with the requester that filled it.
module packer_fifo_sched
    import packer_fifo_sched_pkg::*;
#(
    parameter  int unsigned NumReq = 4,
    parameter  int unsigned InW    = 8,
    parameter  int unsigned OutW   = 32,
    localparam int unsigned R      = OutW / InW,
    localparam int unsigned CntW   = $clog2(R) + 1,
    localparam int unsigned IdW    = $clog2(NumReq)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic [NumReq-1:0]     cfg_en_i,
    input  logic [NumReq-1:0]     req_valid_i,
    input  logic [NumReq*InW-1:0] req_data_i,
    output logic [NumReq-1:0]     req_ready_o,
    output logic                  pk_clr_o,
    output logic                  pk_wvalid_o,
    output logic [InW-1:0]        pk_wdata_o,
    input  logic                  pk_wready_i,
    input  logic                  pk_rvalid_i,
    input  logic                  pk_rready_i,
    output logic [IdW-1:0]        rid_o,
    output logic                  rid_valid_o,
    output logic                  busy_o
);

    if (OutW <= InW || (OutW % InW) != 0) begin : g_bad_width
        $error("packer_fifo_sched: OutW must exceed InW and be a multiple of it");
    end
    if (NumReq < 2 || NumReq > MaxReq) begin : g_bad_numreq
        $error("packer_fifo_sched: NumReq out of range");
    end

    sched_state_e    state_q;
    logic [IdW-1:0]  owner_q;
    logic [IdW-1:0]  rr_ptr_q;
    logic [CntW-1:0] beat_cnt_q;

    logic [NumReq-1:0] elig;
    logic [IdW-1:0]    pick_idx;
    logic              pick_any;
    logic [IdW-1:0]    next_ptr;
    logic              beat;
    logic              last_beat;
    logic              pop;
    logic              drain;

    assign elig = req_valid_i & cfg_en_i;

    packer_fifo_sched_rr_pick #(
        .NumReq (NumReq)
    ) u_rr_pick (
        .elig_i (elig),
        .ptr_i  (rr_ptr_q),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // Owner's write channel is routed straight through to the packer while filling.
    always_comb begin
        req_ready_o = '0;
        pk_wvalid_o = 1'b0;
        pk_wdata_o  = '0;
        if (state_q == FILL && !rst_i && !clr_i) begin
            pk_wvalid_o          = req_valid_i[owner_q];
            pk_wdata_o           = req_data_i[32'(owner_q)*InW +: InW];
            req_ready_o[owner_q] = pk_wready_i;
        end
    end

    assign beat      = pk_wvalid_o & pk_wready_i;
    assign last_beat = beat && (beat_cnt_q == CntW'(R - 1));
    assign pop       = pk_rvalid_i & pk_rready_i;
    assign drain     = (state_q == DRAIN);
    assign next_ptr  = (owner_q == IdW'(NumReq - 1)) ? '0 : owner_q + IdW'(1);

    assign pk_clr_o    = rst_i | clr_i;
    assign busy_o      = (state_q != IDLE);
    assign rid_valid_o = drain;
    assign rid_o       = drain ? owner_q : '0;

    // Ownership is released only once the full word has left the packer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else if (clr_i) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        owner_q <= pick_idx;
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (last_beat) begin
                        state_q    <= DRAIN;
                        beat_cnt_q <= '0;
                    end else if (beat) begin
                        beat_cnt_q <= beat_cnt_q + CntW'(1);
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= next_ptr;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert ($onehot0(req_ready_o));
            assert (!pk_wvalid_o || state_q == FILL);
            assert (!(pk_rvalid_i && !clr_i) || state_q == DRAIN);
        end
    end

endmodule

// File: tb/tb_packer_fifo_sched.sv
// Directed bench for packer_fifo_sched with a behavioural pack-mode packer attached.
module tb_packer_fifo_sched;

    localparam int unsigned NumReq = 4;
    localparam int unsigned InW    = 8;
    localparam int unsigned OutW   = 32;
    localparam int unsigned R      = OutW / InW;
    localparam int unsigned CntW   = $clog2(R) + 1;
    localparam int unsigned IdW    = $clog2(NumReq);

    logic                  clk;
    logic                  rst;
    logic                  clr;
    logic [NumReq-1:0]     cfg_en;
    logic [NumReq-1:0]     req_valid;
    logic [NumReq*InW-1:0] req_data;
    logic [NumReq-1:0]     req_ready;
    logic                  pk_clr;
    logic                  pk_wvalid;
    logic [InW-1:0]        pk_wdata;
    logic                  pk_wready;
    logic                  pk_rvalid;
    logic                  rready;
    logic [IdW-1:0]        rid;
    logic                  rid_valid;
    logic                  busy;

    int checks   = 0;
    int failures = 0;

    packer_fifo_sched #(
        .NumReq (NumReq),
        .InW    (InW),
        .OutW   (OutW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clr_i       (clr),
        .cfg_en_i    (cfg_en),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .pk_clr_o    (pk_clr),
        .pk_wvalid_o (pk_wvalid),
        .pk_wdata_o  (pk_wdata),
        .pk_wready_i (pk_wready),
        .pk_rvalid_i (pk_rvalid),
        .pk_rready_i (rready),
        .rid_o       (rid),
        .rid_valid_o (rid_valid),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural packer: first beat lands in the LSBs, wready held low one cycle after clr.
    logic [OutW-1:0] pk_buf;
    logic [CntW-1:0] pk_cnt;
    logic            pk_full;
    logic            pk_hold;
    assign pk_wready = !pk_full && !pk_hold;
    assign pk_rvalid = pk_full;

    always @(posedge clk) begin
        if (pk_clr) begin
            pk_cnt  <= '0;
            pk_full <= 1'b0;
            pk_hold <= 1'b1;
            pk_buf  <= '0;
        end else begin
            pk_hold <= 1'b0;
            if (pk_wvalid && pk_wready) begin
                pk_buf[32'(pk_cnt)*InW +: InW] <= pk_wdata;
                if (pk_cnt == CntW'(R - 1)) begin
                    pk_cnt  <= '0;
                    pk_full <= 1'b1;
                end else begin
                    pk_cnt <= pk_cnt + CntW'(1);
                end
            end
            if (pk_full && rready) pk_full <= 1'b0;
        end
    end

    // Requester k presents base[k] + n*inc[k] for its n-th accepted beat.
    logic [7:0] base    [NumReq];
    logic [7:0] inc     [NumReq];
    logic [7:0] acc_cnt [NumReq];
    logic       cnt_rst;

    always @(posedge clk) begin
        for (int k = 0; k < int'(NumReq); k++) begin
            if (cnt_rst) acc_cnt[k] <= '0;
            else if (req_valid[k] && req_ready[k]) acc_cnt[k] <= acc_cnt[k] + 8'd1;
        end
    end

    always_comb begin
        req_data = '0;
        for (int k = 0; k < int'(NumReq); k++) begin
            req_data[k*InW +: InW] = base[k] + 8'(acc_cnt[k] * inc[k]);
        end
    end

    typedef struct {
        logic [IdW-1:0]  id;
        logic [OutW-1:0] word;
        logic            rv;
        int              cyc;
    } pop_t;

    pop_t pops[$];
    pop_t mon_e;
    int   cyc = 0;
    int   pop_idx = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && !clr && pk_rvalid && rready) begin
            mon_e.id   = rid;
            mon_e.word = pk_buf;
            mon_e.rv   = rid_valid;
            mon_e.cyc  = cyc;
            pops.push_back(mon_e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag, input logic [IdW-1:0] exp_id, input logic [OutW-1:0] exp_word);
        if (pop_idx < pops.size()) begin
            chk({tag, "_id"}, 64'(pops[pop_idx].id), 64'(exp_id));
            chk({tag, "_word"}, 64'(pops[pop_idx].word), 64'(exp_word));
            chk({tag, "_ridv"}, 64'(pops[pop_idx].rv), 64'd1);
        end else begin
            chk({tag, "_missing"}, 64'(pops.size()), 64'(pop_idx + 1));
        end
        pop_idx++;
    endtask

    task automatic wait_pops(input string tag, input int n, input int budget);
        int b = 0;
        while (pops.size() < n && b < budget) begin
            tick();
            b++;
        end
        chk(tag, 64'(pops.size() >= n), 64'd1);
    endtask

    task automatic clr_counts();
        cnt_rst = 1'b1;
        tick();
        cnt_rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int b;
        rst       = 1'b1;
        clr       = 1'b0;
        cfg_en    = 4'hF;
        req_valid = '0;
        rready    = 1'b1;
        cnt_rst   = 1'b1;
        for (int k = 0; k < int'(NumReq); k++) begin
            base[k] = 8'(k << 4);
            inc[k]  = 8'd1;
        end
        tick();
        tick();

        // Reset values while rst is held
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_wvalid", 64'(pk_wvalid), 64'h0);
        chk("rst_wdata", 64'(pk_wdata), 64'h0);
        chk("rst_rid", 64'(rid), 64'h0);
        chk("rst_ridv", 64'(rid_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_pkclr", 64'(pk_clr), 64'h1);

        // Single requester 1 sends 11,22,33,44
        base[1]   = 8'h11;
        inc[1]    = 8'h11;
        rst       = 1'b0;
        cnt_rst   = 1'b0;
        req_valid = 4'b0010;
        chk("t1_idle_ready", 64'(req_ready), 64'h0);
        tick();
        chk("t1_grant_busy", 64'(busy), 64'h1);
        chk("t1_grant_ready", 64'(req_ready), 64'h2);
        chk("t1_wvalid", 64'(pk_wvalid), 64'h1);
        chk("t1_wdata", 64'(pk_wdata), 64'h11);
        repeat (4) tick();
        chk("t1_drain_ridv", 64'(rid_valid), 64'h1);
        chk("t1_drain_rid", 64'(rid), 64'h1);
        chk("t1_drain_ready", 64'(req_ready), 64'h0);
        req_valid = '0;
        tick();
        chk("t1_idle_busy", 64'(busy), 64'h0);
        chk("t1_rr_ptr", 64'(dut.rr_ptr_q), 64'h2);
        chk_pop("t1_pop", 2'd1, 32'h44332211);

        // All four valid: owners 0,1,2,3,0 and each word carries one ID
        rst     = 1'b1;
        cnt_rst = 1'b1;
        base[1] = 8'h10;
        inc[1]  = 8'h01;
        tick();
        rst     = 1'b0;
        cnt_rst = 1'b0;
        chk("t2_rr_ptr_rst", 64'(dut.rr_ptr_q), 64'h0);
        p0 = pop_idx;
        req_valid = 4'hF;
        wait_pops("t2_wait", p0 + 5, 80);
        req_valid = '0;
        chk_pop("t2_w0", 2'd0, 32'h03020100);
        chk_pop("t2_w1", 2'd1, 32'h13121110);
        chk_pop("t2_w2", 2'd2, 32'h23222120);
        chk_pop("t2_w3", 2'd3, 32'h33323130);
        chk_pop("t2_w4", 2'd0, 32'h07060504);
        if (pops.size() >= p0 + 5) begin
            chk("t2_rate", 64'(pops[p0+4].cyc - pops[p0].cyc), 64'(4 * (R + 2)));
        end

        // Requester 2 stalls mid-word; requester 3 must wait
        clr_counts();
        req_valid = 4'b0100;
        tick();
        chk("t3_grant", 64'(req_ready), 64'h4);
        tick();
        tick();
        req_valid = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_stall_ready", 64'(req_ready), 64'h4);
        end
        chk("t3_stall_wvalid", 64'(pk_wvalid), 64'h0);
        req_valid = 4'b1100;
        tick();
        tick();
        chk("t3_drain_rid", 64'(rid), 64'h2);
        chk("t3_drain_ready", 64'(req_ready), 64'h0);
        p0 = pop_idx;
        wait_pops("t3_wait2", p0 + 1, 10);
        chk_pop("t3_w2", 2'd2, 32'h23222120);
        wait_pops("t3_wait3", p0 + 2, 20);
        req_valid = '0;
        chk_pop("t3_w3", 2'd3, 32'h33323130);

        // clr after 3 beats flushes the partial word
        clr_counts();
        req_valid = 4'b0001;
        tick();
        tick();
        tick();
        tick();
        chk("t4_partial", 64'(pk_cnt), 64'h3);
        clr = 1'b1;
        #1;
        chk("t4_clr_pkclr", 64'(pk_clr), 64'h1);
        chk("t4_clr_ready", 64'(req_ready), 64'h0);
        chk("t4_clr_wvalid", 64'(pk_wvalid), 64'h0);
        tick();
        clr = 1'b0;
        chk("t4_idle_busy", 64'(busy), 64'h0);
        chk("t4_depth", 64'({pk_full, pk_cnt}), 64'h0);
        chk("t4_rr_ptr", 64'(dut.rr_ptr_q), 64'h0);
        p0 = pop_idx;
        wait_pops("t4_wait", p0 + 1, 20);
        req_valid = '0;
        chk_pop("t4_w0", 2'd0, 32'h06050403);

        // Downstream back-pressure in DRAIN
        clr_counts();
        rready    = 1'b0;
        req_valid = 4'b0110;
        b = 0;
        while (!rid_valid && b < 20) begin
            tick();
            b++;
        end
        chk("t5_reach_drain", 64'(rid_valid), 64'h1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_hold_ready", 64'(req_ready), 64'h0);
            chk("t5_hold_rid", 64'(rid), 64'h1);
        end
        rready = 1'b1;
        tick();
        req_valid = '0;
        chk("t5_pop_busy", 64'(busy), 64'h0);
        chk("t5_pop_ridv", 64'(rid_valid), 64'h0);
        chk_pop("t5_w1", 2'd1, 32'h13121110);

        // Only IDs 0 and 2 enabled; then reset mid-FILL
        clr_counts();
        cfg_en    = 4'b0101;
        req_valid = 4'hF;
        p0 = pop_idx;
        wait_pops("t6_wait", p0 + 4, 60);
        chk_pop("t6_w0", 2'd2, 32'h23222120);
        chk_pop("t6_w1", 2'd0, 32'h03020100);
        chk_pop("t6_w2", 2'd2, 32'h27262524);
        chk_pop("t6_w3", 2'd0, 32'h07060504);
        tick();
        tick();
        tick();
        chk("t6_fill_ready", 64'(req_ready), 64'h4);
        rst = 1'b1;
        tick();
        chk("t6_rst_ready", 64'(req_ready), 64'h0);
        chk("t6_rst_wvalid", 64'(pk_wvalid), 64'h0);
        chk("t6_rst_wdata", 64'(pk_wdata), 64'h0);
        chk("t6_rst_rid", 64'(rid), 64'h0);
        chk("t6_rst_ridv", 64'(rid_valid), 64'h0);
        chk("t6_rst_busy", 64'(busy), 64'h0);
        chk("t6_rst_pkclr", 64'(pk_clr), 64'h1);
        chk("t6_rst_rr_ptr", 64'(dut.rr_ptr_q), 64'h0);
        rst       = 1'b0;
        req_valid = '0;
        cfg_en    = 4'hF;
        tick();
        chk("t6_post_depth", 64'({pk_full, pk_cnt}), 64'h0);
        chk("t6_post_busy", 64'(busy), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
